// File: rtl/arith_pkg.sv
// ============================================================================
// Module      : arith_pkg
// Description : Shared arithmetic constants and the accumulator state type
//               for product_accumulator.
// Contents    : PROD_W_DEF, ACC_W_DEF, CNT_W_DEF - default widths
//               acc_state_e                      - ACCUM / HOLD state encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;
  localparam int CNT_W_DEF  = 5;

  // ACCUM: collecting products; HOLD: presenting a finished frame result.
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

endpackage : arith_pkg

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// Module      : product_accumulator
// Description : Sums a frame of unsigned multiplier products (valid/ready in,
//               valid/ready out). A beat with in_last closes the frame; its
//               sum, beat count and sticky overflow are held until the
//               downstream handshake, after which a new frame starts.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               in_valid/ready  - upstream handshake
//               in_data         - unsigned product (PROD_W)
//               in_last         - closes the current frame
//               out_valid/ready - downstream handshake
//               out_sum         - frame sum mod 2^ACC_W
//               out_count       - beats in frame, saturating at 2^CNT_W-1
//               out_ovf         - sum wrapped at least once in the frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator
  import arith_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              ovf_q,   ovf_d;
  logic [ACC_W-1:0]  sum_q,   sum_d;
  logic [CNT_W-1:0]  ocnt_q,  ocnt_d;
  logic              oovf_q,  oovf_d;

  logic              w_accept;
  logic              w_release;
  logic [ACC_W:0]    w_add;      // one extra bit captures the carry-out
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ovf_nxt;

  assign w_accept  = in_valid && (state_q == ST_ACCUM);
  assign w_release = out_ready && (state_q == ST_HOLD);

  assign w_add     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_data};
  assign w_acc_nxt = w_add[ACC_W-1:0];
  assign w_ovf_nxt = ovf_q | w_add[ACC_W];
  assign w_cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State register (plus datapath registers sharing the same reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (w_accept) begin
          acc_d = w_acc_nxt;
          cnt_d = w_cnt_nxt;
          ovf_d = w_ovf_nxt;
          if (in_last) begin
            // Result includes the closing beat itself.
            sum_d   = w_acc_nxt;
            ocnt_d  = w_cnt_nxt;
            oovf_d  = w_ovf_nxt;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_release) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_HOLD);
    out_sum   = sum_q;
    out_count = ocnt_q;
    out_ovf   = oovf_q;
  end

endmodule : product_accumulator

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// Module      : tb_product_accumulator
// Description : Directed self-checking bench for product_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 12;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  product_accumulator #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic beat(input int d, input bit l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d[PROD_W-1:0];
    in_last  = l;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("beat_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int s, input int c, input int o);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_sum"},   int'(out_sum),   s);
    chk({tag, "_count"}, int'(out_count), c);
    chk({tag, "_ovf"},   int'(out_ovf),   o);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, int'(out_valid), 0);
    chk({tag, "_rel_ready"}, int'(in_ready),  1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum",   int'(out_sum),   0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_ovf",   int'(out_ovf),   0);

    // Basic frame with out_ready held high; latency check on out_valid.
    out_ready = 1'b1;
    beat(12, 0); beat(10, 0); beat(14, 0);
    chk("t1_pre_valid", int'(out_valid), 0);
    beat(32, 1);
    check_result("t1", 68, 4, 0);
    tick();
    out_ready = 1'b0;
    chk("t1_done_valid", int'(out_valid), 0);
    chk("t1_done_ready", int'(in_ready),  1);

    // Overflow: 17 x 255 = 4335 -> 239 mod 4096.
    for (int i = 0; i < 17; i++) beat(255, i == 16);
    check_result("t2", 239, 17, 1);
    release_result("t2");

    // Back-pressure in HOLD with a pending upstream beat.
    beat(9, 1);
    in_valid = 1'b1; in_data = 8'd50; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_result("t3_hold", 9, 1, 0);
      chk("t3_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_hs_valid", int'(out_valid), 0);
    chk("t3_hs_ready", int'(in_ready),  1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check_result("t3_pending", 50, 1, 0);
    release_result("t3");

    // Single-beat frame of zero, then a fresh 3-beat frame.
    beat(0, 1);
    check_result("t4a", 0, 1, 0);
    release_result("t4a");
    beat(5, 0); beat(5, 0); beat(5, 1);
    check_result("t4b", 15, 3, 0);
    release_result("t4b");

    // Reset aborts a partial frame.
    beat(100, 0); beat(100, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_ready", int'(in_ready),  1);
    tick();
    chk("t5_idle_valid", int'(out_valid), 0);
    beat(7, 1);
    check_result("t5", 7, 1, 0);
    release_result("t5");

    // Count saturation: 33 beats of 1.
    for (int i = 0; i < 33; i++) beat(1, i == 32);
    check_result("t6", 33, 31, 0);
    release_result("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_product_accumulator

`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter PROD_W, default 8, meaning width of each incoming product.
REQ-002 The block SHALL have parameter ACC_W, default 12, meaning width of the running sum (ACC_W > PROD_W).
REQ-003 The block SHALL have parameter CNT_W, default 5, meaning width of the beat counter.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1, meaning the upstream multiplier product is valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts a product this cycle.
REQ-008 The block SHALL have port in_data, input, PROD_W, meaning the unsigned product.
REQ-009 The block SHALL have port in_last, input, 1, meaning this product closes the current frame.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the frame result is valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-012 The block SHALL have port out_sum, output, ACC_W, meaning the frame sum modulo 2^ACC_W.
REQ-013 The block SHALL have port out_count, output, CNT_W, meaning the number of products in the frame.
REQ-014 The block SHALL have port out_ovf, output, 1, meaning the sum exceeded 2^ACC_W-1 at least once in the frame.

Function
REQ-015 The block SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 The block SHALL accept a beat only when in_valid and in_ready are both 1.
REQ-017 On acceptance in ACCUM, the block SHALL set acc <= acc + in_data, zero-extended and wrapping mod 2^ACC_W.
REQ-018 On an accepted beat, ovf SHALL be set sticky when the addition carries out of ACC_W.
REQ-019 On an accepted beat, count SHALL increment, saturating at 2^CNT_W-1.
REQ-020 An accepted beat with in_last=1 SHALL load out_sum, out_count and out_ovf with the values including that beat, and move the block to HOLD; out_valid SHALL rise on the next cycle (latency 1 cycle).
REQ-021 In HOLD, out_sum, out_count and out_ovf SHALL remain stable until out_valid and out_ready are both 1.
REQ-022 On the HOLD handshake, the block SHALL clear acc, count and ovf and return to ACCUM; in_ready SHALL be 1 on the following cycle, with no bubble beyond that.
REQ-023 In HOLD, the block SHALL ignore in_valid and SHALL NOT alter the upstream beat.
REQ-024 A single-beat frame (in_last on the first beat) SHALL be legal and produce count=1.
REQ-025 in_valid=0 cycles SHALL leave all state unchanged.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter ACCUM and set acc=0, count=0 and ovf=0.
REQ-027 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_sum=0, out_count=0 and out_ovf=0; in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-028 Reset SHALL discard a partially accumulated frame or a held result, with no output handshake.
REQ-029 rst SHALL have priority over any simultaneous handshake.

Structure
REQ-030 A shared package arith_pkg SHALL hold the default PROD_W, ACC_W and CNT_W constants and the two-state enum type.
REQ-031 The block SHALL be flat with no sub-module; the state register, accumulator and counter live in one module.

Verification
REQ-032 The bench SHALL drive products 12, 10, 14 and 32 (last on 32) with out_ready=1 and check out_sum=68, out_count=4, out_ovf=0, and out_valid exactly one cycle after the last beat.
REQ-033 The bench SHALL drive 17 beats of 255 (last on the 17th) and check out_sum=239 (4335 mod 4096), out_count=17, out_ovf=1.
REQ-034 The bench SHALL hold out_ready=0 for 3 cycles in HOLD and check outputs stable, in_ready=0, and a pending in_valid beat not consumed until one cycle after the handshake.
REQ-035 The bench SHALL drive a single beat of 0 with in_last and check out_sum=0, out_count=1, out_ovf=0; then a 3-beat frame of 5s and check out_sum=15, out_count=3 (accumulator cleared between frames).
REQ-036 The bench SHALL accept 2 beats of 100, assert rst for 1 cycle, then send 7 (last) and check out_sum=7, out_count=1, and no result emitted for the aborted frame.
REQ-037 The bench SHALL send 33 beats of 1 (last on the 33rd) and check out_count=31 (saturated), out_sum=33.
